mux_nto1_pipe: RTL and testbench

//   Parametrised N-to-1 datapath selector with a one-deep registered output and valid/ready handshake.

---
 rtl/mux_nto1_pipe_pkg.sv | 14 +
 rtl/mux_nto1_pipe_if.sv | 32 +++
 rtl/mux_nto1_pipe_rr_arbiter.sv | 36 +++
 rtl/mux_nto1_pipe.sv | 114 +++++++++++
 tb/tb_mux_nto1_pipe.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mux_nto1_pipe_pkg.sv
// Shared definitions for the N-to-1 pipelined datapath selector:
// default datapath width and the arbitration mode encoding.
package mux_nto1_pipe_pkg;

    localparam int   DP_WIDTH     = 32;
    localparam logic MUX_MODE_SEL = 1'b0;
    localparam logic MUX_MODE_RR  = 1'b1;

    typedef enum logic {
        MODE_SEL = MUX_MODE_SEL,
        MODE_RR  = MUX_MODE_RR
    } mux_mode_e;

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Producer/consumer bundle of the selector: N input channels, mode/select
// controls, one registered output channel and the select-error pulse.
interface mux_nto1_pipe_if
    import mux_nto1_pipe_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int N     = 4,
    parameter int SEL_W = 2
);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               rr_en;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;
    logic               err_sel;

    modport master (
        output in_data, in_valid, sel, rr_en, out_ready,
        input  in_ready, out_data, out_src, out_valid, err_sel
    );

    modport slave (
        input  in_data, in_valid, sel, rr_en, out_ready,
        output in_ready, out_data, out_src, out_valid, err_sel
    );

endinterface

// File: rtl/mux_nto1_pipe_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo N (N need not be a power of two).
module rr_arbiter
    import mux_nto1_pipe_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] scan_idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        scan_idx  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!grant_vld && req[scan_idx]) begin
                grant_vld          = 1'b1;
                grant_idx          = scan_idx;
                grant_oh[scan_idx] = 1'b1;
            end
            // explicit wrap: natural overflow would visit invalid indices when N < 2**SEL_W
            scan_idx = (scan_idx == LAST) ? '0 : scan_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-to-1 datapath selector with explicit-select or round-robin arbitration,
// valid/ready handshake and a single registered output slot.
module mux_nto1_pipe
    import mux_nto1_pipe_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_nto1_pipe_if.slave    bus
);

    if (N < 2) begin : g_bad_n
        $error("mux_nto1_pipe: N must be at least 2");
    end
    if (SEL_W != $clog2(N)) begin : g_bad_sel_w
        $error("mux_nto1_pipe: SEL_W must equal clog2(N)");
    end

    localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + SEL_W'(1);
    endfunction

    mux_mode_e        mode;
    logic [SEL_W-1:0] ptr;
    logic             load_en;
    logic             sel_ok;
    logic             sel_err;
    logic             sel_err_q;
    logic [N-1:0]     rr_oh;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [N-1:0]     ready_oh;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     ready;
    logic             xfer;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;
    logic             out_valid_q;
    logic             err_sel_q;

    assign mode    = mux_mode_e'(bus.rr_en);
    assign load_en = !out_valid_q || bus.out_ready;
    assign sel_ok  = {1'b0, bus.sel} < N_EXT;
    assign sel_err = (mode == MODE_SEL) && !sel_ok;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .grant_oh  (rr_oh),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Stage 0: choose the candidate channel for this cycle
    always_comb begin
        ready_oh  = '0;
        grant_idx = '0;
        if (mode == MODE_RR) begin
            if (rr_vld) begin
                ready_oh  = rr_oh;
                grant_idx = rr_idx;
            end
        end else if (sel_ok) begin
            ready_oh[bus.sel] = 1'b1;
            grant_idx         = bus.sel;
        end
    end

    assign ready        = (rst_n && load_en) ? ready_oh : '0;
    assign xfer         = |(bus.in_valid & ready);
    assign sel_word     = bus.in_data[grant_idx*WIDTH +: WIDTH];
    assign bus.in_ready = ready;

    // Stage 1: output slot, rr pointer and select-error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_sel_q   <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr         <= '0;
        end else begin
            sel_err_q <= sel_err;
            err_sel_q <= sel_err && !sel_err_q;
            if (xfer) begin
                out_data_q  <= sel_word;
                out_src_q   <= grant_idx;
                out_valid_q <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr <= wrap_inc(grant_idx);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_sel   = err_sel_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-channel and a 3-channel instance
// exercised through reset, explicit select, round-robin and backpressure.
module tb_mux_nto1_pipe;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [31:0] d4 [4];
    logic [31:0] d3 [3];

    mux_nto1_pipe_if #(.WIDTH(32), .N(4), .SEL_W(2)) bus4 ();
    mux_nto1_pipe_if #(.WIDTH(32), .N(3), .SEL_W(2)) bus3 ();

    mux_nto1_pipe #(.WIDTH(32), .N(4), .SEL_W(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux_nto1_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_d4();
        for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = d4[i];
    endtask

    task automatic load_d3();
        for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = d3[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.in_data = '0; bus4.in_valid = 4'hF; bus4.sel = 2'd0; bus4.rr_en = 1'b0; bus4.out_ready = 1'b1;
        bus3.in_data = '0; bus3.in_valid = 3'h7; bus3.sel = 2'd0; bus3.rr_en = 1'b0; bus3.out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        n_cmp++; if (bus4.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus4.out_data); end
        n_cmp++; if (bus4.out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src: got %0d want 0", bus4.out_src); end
        n_cmp++; if (bus4.in_ready !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus4.in_ready); end
        n_cmp++; if (bus4.err_sel !== 1'b0) begin n_fail++; $display("FAIL reset_err_sel: got %b want 0", bus4.err_sel); end
        n_cmp++; if (bus3.in_ready !== 3'h0) begin n_fail++; $display("FAIL reset_in_ready_n3: got %b want 000", bus3.in_ready); end
        n_cmp++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_n3: got %b want 0", bus3.out_valid); end
        bus4.in_valid = 4'h0;
        bus3.in_valid = 3'h0;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b want 0", bus4.out_valid); end
    endtask

    task automatic test_explicit();
        d4[0] = 32'h1; d4[1] = 32'h10; d4[2] = 32'h100; d4[3] = 32'h10000;
        load_d4();
        bus4.rr_en = 1'b0; bus4.out_ready = 1'b1; bus4.in_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus4.sel = 2'(i);
            #1;
            n_cmp++; if (bus4.in_ready !== 4'(1 << i)) begin n_fail++; $display("FAIL explicit_in_ready[%0d]: got %b want %b", i, bus4.in_ready, 4'(1 << i)); end
            tick();
            n_cmp++; if (bus4.out_data !== d4[i]) begin n_fail++; $display("FAIL explicit_data[%0d]: got %h want %h", i, bus4.out_data, d4[i]); end
            n_cmp++; if (bus4.out_src !== 2'(i)) begin n_fail++; $display("FAIL explicit_src[%0d]: got %0d want %0d", i, bus4.out_src, i); end
            n_cmp++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL explicit_valid[%0d]: got %b want 1", i, bus4.out_valid); end
            n_cmp++; if (bus4.err_sel !== 1'b0) begin n_fail++; $display("FAIL explicit_err_sel[%0d]: got %b want 0", i, bus4.err_sel); end
        end
        bus4.in_valid = 4'h0;
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL explicit_drain_valid: got %b want 0", bus4.out_valid); end
        n_cmp++; if (bus4.out_data !== 32'h10000) begin n_fail++; $display("FAIL explicit_drain_hold: got %h want 00010000", bus4.out_data); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src [9];
        exp_src = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) d4[i] = 32'h0A00_0000 + i;
        load_d4();
        bus4.rr_en = 1'b1; bus4.out_ready = 1'b1; bus4.in_valid = 4'b1010;
        #1;
        n_cmp++; if (bus4.in_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_first_ready: got %b want 0010", bus4.in_ready); end
        for (int k = 0; k < 9; k++) begin
            if (k == 4) bus4.in_valid = 4'hF;
            tick();
            n_cmp++; if (bus4.out_src !== exp_src[k]) begin n_fail++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, bus4.out_src, exp_src[k]); end
            n_cmp++; if (bus4.out_data !== d4[exp_src[k]]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus4.out_data, d4[exp_src[k]]); end
        end
        bus4.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        bus4.rr_en = 1'b0; bus4.sel = 2'd2; bus4.in_valid = 4'hF; bus4.out_ready = 1'b0;
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", bus4.out_valid); end
        n_cmp++; if (bus4.out_data !== 32'h0A00_0002) begin n_fail++; $display("FAIL bp_first_data: got %h want 0a000002", bus4.out_data); end
        bus4.in_data[64 +: 32] = 32'h0000_ABCD;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus4.in_ready !== 4'h0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, bus4.in_ready); end
            tick();
            n_cmp++; if (bus4.out_data !== 32'h0A00_0002) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h want 0a000002", c, bus4.out_data); end
            n_cmp++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, bus4.out_valid); end
        end
        bus4.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus4.in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", bus4.in_ready); end
        tick();
        n_cmp++; if (bus4.out_data !== 32'h0000_ABCD) begin n_fail++; $display("FAIL bp_reload_data: got %h want 0000abcd", bus4.out_data); end
        n_cmp++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid: got %b want 1", bus4.out_valid); end
        bus4.in_valid = 4'h0;
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid: got %b want 0", bus4.out_valid); end
    endtask

    task automatic test_n3();
        for (int i = 0; i < 3; i++) d3[i] = 32'h3000_0000 + i;
        load_d3();
        bus3.rr_en = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'h7; bus3.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus3.in_ready !== 3'h0) begin n_fail++; $display("FAIL n3_badsel_ready: got %b want 000", bus3.in_ready); end
        tick();
        n_cmp++; if (bus3.err_sel !== 1'b1) begin n_fail++; $display("FAIL n3_err_pulse: got %b want 1", bus3.err_sel); end
        n_cmp++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL n3_badsel_no_xfer: got %b want 0", bus3.out_valid); end
        bus3.sel = 2'd0; bus3.in_valid = 3'h0;
        tick();
        n_cmp++; if (bus3.err_sel !== 1'b0) begin n_fail++; $display("FAIL n3_err_clear: got %b want 0", bus3.err_sel); end
        bus3.rr_en = 1'b1; bus3.in_valid = 3'b100;
        #1;
        n_cmp++; if (bus3.in_ready !== 3'b100) begin n_fail++; $display("FAIL n3_rr_ready: got %b want 100", bus3.in_ready); end
        tick();
        n_cmp++; if (bus3.out_src !== 2'd2) begin n_fail++; $display("FAIL n3_rr_src2: got %0d want 2", bus3.out_src); end
        n_cmp++; if (bus3.out_data !== d3[2]) begin n_fail++; $display("FAIL n3_rr_data2: got %h want %h", bus3.out_data, d3[2]); end
        bus3.in_valid = 3'h7;
        tick();
        n_cmp++; if (bus3.out_src !== 2'd0) begin n_fail++; $display("FAIL n3_rr_wrap: got %0d want 0", bus3.out_src); end
        n_cmp++; if (bus3.out_data !== d3[0]) begin n_fail++; $display("FAIL n3_rr_wrap_data: got %h want %h", bus3.out_data, d3[0]); end
        bus3.in_valid = 3'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus4.rr_en = 1'b1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b0;
        tick();
        n_cmp++; if (bus4.out_src !== 2'd1) begin n_fail++; $display("FAIL mid_pre_src: got %0d want 1", bus4.out_src); end
        n_cmp++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus4.out_valid); end
        bus4.in_valid = 4'h0;
        tick();
        rst_n = 1'b0; bus4.in_valid = 4'hF;
        #1;
        n_cmp++; if (bus4.in_ready !== 4'h0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0000", bus4.in_ready); end
        tick();
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus4.out_valid); end
        n_cmp++; if (bus4.out_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0", bus4.out_data); end
        n_cmp++; if (bus4.out_src !== 2'd0) begin n_fail++; $display("FAIL mid_reset_src: got %0d want 0", bus4.out_src); end
        rst_n = 1'b1; bus4.in_valid = 4'b1010; bus4.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus4.in_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_after_ready: got %b want 0010", bus4.in_ready); end
        tick();
        n_cmp++; if (bus4.out_src !== 2'd1) begin n_fail++; $display("FAIL mid_after_src: got %0d want 1", bus4.out_src); end
        n_cmp++; if (bus4.out_data !== 32'h0A00_0001) begin n_fail++; $display("FAIL mid_after_data: got %h want 0a000001", bus4.out_data); end
        bus4.in_valid = 4'h0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_explicit();
        test_round_robin();
        test_backpressure();
        test_n3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
